// File: rtl/branch_redirect_ctrl_if.sv
// rtl/branch_redirect_ctrl_if.sv - execute/fetch redirect bus for branch_redirect_ctrl
interface branch_redirect_ctrl_if #(
  parameter int AWIDTH = 32,
  parameter int CNTW   = 32
);
  logic              br_valid_i;
  logic [6:0]        br_opcode_i;
  logic [2:0]        br_funct3_i;
  logic              breq_i;
  logic              brlt_i;
  logic [AWIDTH-1:0] target_i;
  logic              redirect_ready_i;
  logic              redirect_valid_o;
  logic [AWIDTH-1:0] redirect_pc_o;
  logic              flush_o;
  logic              stall_o;
  logic              misalign_o;
  logic [CNTW-1:0]   branch_cnt_o;
  logic [CNTW-1:0]   taken_cnt_o;

  modport master (
    output br_valid_i, br_opcode_i, br_funct3_i, breq_i, brlt_i, target_i, redirect_ready_i,
    input  redirect_valid_o, redirect_pc_o, flush_o, stall_o, misalign_o, branch_cnt_o, taken_cnt_o
  );

  modport slave (
    input  br_valid_i, br_opcode_i, br_funct3_i, breq_i, brlt_i, target_i, redirect_ready_i,
    output redirect_valid_o, redirect_pc_o, flush_o, stall_o, misalign_o, branch_cnt_o, taken_cnt_o
  );
endinterface

// File: rtl/branch_redirect_ctrl.sv
// rtl/branch_redirect_ctrl.sv - predict-not-taken redirect sequencer with flush window and counters
module branch_redirect_ctrl #(
  parameter int AWIDTH       = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNTW         = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  branch_redirect_ctrl_if.slave bus
);
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam int FW = (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;

  typedef enum logic [1:0] {IDLE, REDIRECT, FLUSH} state_t;

  state_t            state, state_nx;
  logic [AWIDTH-1:0] pc_q, pc_nx;
  logic [FW-1:0]     fcnt_q, fcnt_nx;
  logic [CNTW-1:0]   bcnt_q, bcnt_nx;
  logic [CNTW-1:0]   tcnt_q, tcnt_nx;
  logic              mis_q, mis_nx;
  logic              is_cf;
  logic              taken;
  logic [AWIDTH-1:0] eff_target;

  // Decode the resolved instruction into control-flow / taken / effective target
  always_comb begin
    is_cf      = 1'b0;
    taken      = 1'b0;
    eff_target = bus.target_i;
    case (bus.br_opcode_i)
      OP_BRANCH: begin
        is_cf = 1'b1;
        case (bus.br_funct3_i)
          3'b000:         taken = bus.breq_i;
          3'b001:         taken = !bus.breq_i;
          3'b100, 3'b110: taken = bus.brlt_i;
          3'b101, 3'b111: taken = !bus.brlt_i;
          default:        taken = 1'b0;
        endcase
      end
      OP_JAL: begin
        is_cf = 1'b1;
        taken = 1'b1;
      end
      OP_JALR: begin
        is_cf         = 1'b1;
        taken         = 1'b1;
        eff_target[0] = 1'b0;
      end
      default: ;
    endcase
  end

  // Next-state, redirect latch, flush countdown and saturating counters
  always_comb begin
    state_nx = state;
    pc_nx    = pc_q;
    fcnt_nx  = fcnt_q;
    bcnt_nx  = bcnt_q;
    tcnt_nx  = tcnt_q;
    mis_nx   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.br_valid_i && is_cf) begin
          if (bcnt_q != '1) bcnt_nx = bcnt_q + CNTW'(1);
          if (taken) begin
            if (tcnt_q != '1) tcnt_nx = tcnt_q + CNTW'(1);
            if (eff_target[1]) begin
              mis_nx = 1'b1;
            end else begin
              pc_nx    = eff_target;
              state_nx = REDIRECT;
            end
          end
        end
      end
      REDIRECT: begin
        if (bus.redirect_ready_i) begin
          if (FLUSH_CYCLES == 0) begin
            state_nx = IDLE;
          end else begin
            state_nx = FLUSH;
            fcnt_nx  = FW'(FLUSH_CYCLES);
          end
        end
      end
      FLUSH: begin
        if (fcnt_q <= FW'(1)) state_nx = IDLE;
        else                  fcnt_nx  = fcnt_q - FW'(1);
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register; reset aborts any redirect or flush in progress
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      pc_q   <= '0;
      fcnt_q <= '0;
      bcnt_q <= '0;
      tcnt_q <= '0;
      mis_q  <= 1'b0;
    end else begin
      state  <= state_nx;
      pc_q   <= pc_nx;
      fcnt_q <= fcnt_nx;
      bcnt_q <= bcnt_nx;
      tcnt_q <= tcnt_nx;
      mis_q  <= mis_nx;
    end
  end

  assign bus.redirect_valid_o = (state == REDIRECT);
  assign bus.flush_o          = (state != IDLE);
  assign bus.stall_o          = (state != IDLE);
  assign bus.redirect_pc_o    = pc_q;
  assign bus.misalign_o       = mis_q;
  assign bus.branch_cnt_o     = bcnt_q;
  assign bus.taken_cnt_o      = tcnt_q;
endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// tb/tb_branch_redirect_ctrl.sv - self-checking bench for branch_redirect_ctrl
module tb_branch_redirect_ctrl;
  localparam logic [6:0] BR   = 7'b1100011;
  localparam logic [6:0] JAL  = 7'b1101111;
  localparam logic [6:0] JALR = 7'b1100111;
  localparam logic [6:0] OPR  = 7'b0110011;

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        breq;
    logic        brlt;
    logic [31:0] tgt;
    bit          cf;
    bit          tk;
    int          kind;   // 0 none, 1 redirect, 2 misalign
    logic [31:0] pc;
  } vec_t;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  int   exp_b;
  int   exp_t;
  vec_t vecs[17];
  vec_t sb[$];

  branch_redirect_ctrl_if #(.AWIDTH(32), .CNTW(32)) ifa ();
  branch_redirect_ctrl_if #(.AWIDTH(32), .CNTW(4))  ifb ();

  branch_redirect_ctrl #(.AWIDTH(32), .FLUSH_CYCLES(2), .CNTW(32)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa)
  );
  branch_redirect_ctrl #(.AWIDTH(32), .FLUSH_CYCLES(0), .CNTW(4)) dut_b (
    .clk(clk), .reset(reset), .bus(ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_a(input logic [6:0] op, input logic [2:0] f3, input logic eq,
                         input logic lt, input logic [31:0] tgt);
    ifa.br_valid_i  = 1'b1;
    ifa.br_opcode_i = op;
    ifa.br_funct3_i = f3;
    ifa.breq_i      = eq;
    ifa.brlt_i      = lt;
    ifa.target_i    = tgt;
  endtask

  task automatic apply_vec(input vec_t v, input int idx);
    vec_t e;
    int   fl;
    bit   released;
    @(negedge clk);
    drive_a(v.op, v.f3, v.breq, v.brlt, v.tgt);
    ifa.redirect_ready_i = 1'b1;
    sb.push_back(v);
    @(negedge clk);
    ifa.br_valid_i = 1'b0;
    e = sb.pop_front();
    if (e.cf) exp_b++;
    if (e.tk) exp_t++;
    if (e.kind == 1) begin
      check($sformatf("v%0d_valid", idx), 32'(ifa.redirect_valid_o), 32'd1);
      check($sformatf("v%0d_pc", idx), ifa.redirect_pc_o, e.pc);
      check($sformatf("v%0d_stall", idx), 32'(ifa.stall_o), 32'd1);
      fl = 0;
      released = 1'b0;
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        if (!ifa.stall_o) begin
          released = 1'b1;
          break;
        end
        if (ifa.flush_o && !ifa.redirect_valid_o) fl++;
      end
      check($sformatf("v%0d_release", idx), 32'(released), 32'd1);
      check($sformatf("v%0d_flushlen", idx), 32'(fl), 32'd2);
    end else if (e.kind == 2) begin
      check($sformatf("v%0d_mis", idx), 32'(ifa.misalign_o), 32'd1);
      check($sformatf("v%0d_mis_novalid", idx), 32'(ifa.redirect_valid_o), 32'd0);
      check($sformatf("v%0d_mis_nostall", idx), 32'(ifa.stall_o), 32'd0);
      @(negedge clk);
      check($sformatf("v%0d_mis_pulse", idx), 32'(ifa.misalign_o), 32'd0);
    end else begin
      check($sformatf("v%0d_novalid", idx), 32'(ifa.redirect_valid_o), 32'd0);
      check($sformatf("v%0d_nostall", idx), 32'(ifa.stall_o), 32'd0);
      check($sformatf("v%0d_nomis", idx), 32'(ifa.misalign_o), 32'd0);
    end
    check($sformatf("v%0d_bcnt", idx), ifa.branch_cnt_o, 32'(exp_b));
    check($sformatf("v%0d_tcnt", idx), ifa.taken_cnt_o, 32'(exp_t));
  endtask

  initial begin
    logic [31:0] t;
    int          sat;
    checks   = 0;
    failures = 0;
    exp_b    = 0;
    exp_t    = 0;

    vecs[0]  = '{BR,   3'b000, 1'b1, 1'b0, 32'h0000_0100, 1'b1, 1'b1, 1, 32'h0000_0100};
    vecs[1]  = '{BR,   3'b000, 1'b0, 1'b0, 32'h0000_0180, 1'b1, 1'b0, 0, 32'h0};
    vecs[2]  = '{BR,   3'b001, 1'b0, 1'b1, 32'h0000_0200, 1'b1, 1'b1, 1, 32'h0000_0200};
    vecs[3]  = '{BR,   3'b001, 1'b1, 1'b0, 32'h0000_0280, 1'b1, 1'b0, 0, 32'h0};
    vecs[4]  = '{BR,   3'b100, 1'b0, 1'b1, 32'h0000_0300, 1'b1, 1'b1, 1, 32'h0000_0300};
    vecs[5]  = '{BR,   3'b110, 1'b0, 1'b0, 32'h0000_0380, 1'b1, 1'b0, 0, 32'h0};
    vecs[6]  = '{BR,   3'b101, 1'b0, 1'b1, 32'h0000_0390, 1'b1, 1'b0, 0, 32'h0};
    vecs[7]  = '{BR,   3'b111, 1'b0, 1'b0, 32'h0000_0400, 1'b1, 1'b1, 1, 32'h0000_0400};
    vecs[8]  = '{BR,   3'b010, 1'b1, 1'b1, 32'h0000_0480, 1'b1, 1'b0, 0, 32'h0};
    vecs[9]  = '{JAL,  3'b000, 1'b0, 1'b0, 32'h0000_1000, 1'b1, 1'b1, 1, 32'h0000_1000};
    vecs[10] = '{JALR, 3'b000, 1'b0, 1'b0, 32'h0000_2003, 1'b1, 1'b1, 2, 32'h0};
    vecs[11] = '{JALR, 3'b000, 1'b0, 1'b0, 32'h0000_2001, 1'b1, 1'b1, 1, 32'h0000_2000};
    vecs[12] = '{JAL,  3'b000, 1'b0, 1'b0, 32'h0000_1002, 1'b1, 1'b1, 2, 32'h0};
    vecs[13] = '{BR,   3'b000, 1'b1, 1'b0, 32'h0000_0106, 1'b1, 1'b1, 2, 32'h0};
    vecs[14] = '{OPR,  3'b000, 1'b1, 1'b1, 32'h0000_0500, 1'b0, 1'b0, 0, 32'h0};
    vecs[15] = '{JALR, 3'b000, 1'b1, 1'b0, 32'h8000_3000, 1'b1, 1'b1, 1, 32'h8000_3000};
    vecs[16] = '{BR,   3'b100, 1'b0, 1'b1, 32'h0000_0502, 1'b1, 1'b1, 2, 32'h0};

    reset = 1'b1;
    ifa.br_valid_i = 1'b0; ifa.br_opcode_i = '0; ifa.br_funct3_i = '0;
    ifa.breq_i = 1'b0; ifa.brlt_i = 1'b0; ifa.target_i = '0; ifa.redirect_ready_i = 1'b0;
    ifb.br_valid_i = 1'b0; ifb.br_opcode_i = '0; ifb.br_funct3_i = '0;
    ifb.breq_i = 1'b0; ifb.brlt_i = 1'b0; ifb.target_i = '0; ifb.redirect_ready_i = 1'b1;

    // reset state
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(ifa.redirect_valid_o), 32'd0);
    check("rst_pc", ifa.redirect_pc_o, 32'd0);
    check("rst_flush", 32'(ifa.flush_o), 32'd0);
    check("rst_stall", 32'(ifa.stall_o), 32'd0);
    check("rst_mis", 32'(ifa.misalign_o), 32'd0);
    check("rst_bcnt", ifa.branch_cnt_o, 32'd0);
    check("rst_tcnt", ifa.taken_cnt_o, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 17; i++) apply_vec(vecs[i], i);

    // fetch back-pressure with a stray br_valid_i during the hold
    @(negedge clk);
    drive_a(BR, 3'b001, 1'b0, 1'b0, 32'h0000_0700);
    ifa.redirect_ready_i = 1'b0;
    @(negedge clk);
    ifa.br_valid_i = 1'b0;
    exp_b++;
    exp_t++;
    for (int i = 1; i <= 5; i++) begin
      check($sformatf("bp%0d_valid", i), 32'(ifa.redirect_valid_o), 32'd1);
      check($sformatf("bp%0d_pc", i), ifa.redirect_pc_o, 32'h0000_0700);
      check($sformatf("bp%0d_stall", i), 32'(ifa.stall_o), 32'd1);
      if (i == 2) drive_a(BR, 3'b000, 1'b1, 1'b0, 32'h0000_0900);
      else        ifa.br_valid_i = 1'b0;
      @(negedge clk);
    end
    check("bp6_valid", 32'(ifa.redirect_valid_o), 32'd1);
    check("bp6_pc", ifa.redirect_pc_o, 32'h0000_0700);
    ifa.redirect_ready_i = 1'b1;
    @(negedge clk);
    check("bp_f1_valid", 32'(ifa.redirect_valid_o), 32'd0);
    check("bp_f1_flush", 32'(ifa.flush_o), 32'd1);
    @(negedge clk);
    check("bp_f2_flush", 32'(ifa.flush_o), 32'd1);
    @(negedge clk);
    check("bp_idle_flush", 32'(ifa.flush_o), 32'd0);
    check("bp_idle_stall", 32'(ifa.stall_o), 32'd0);
    check("bp_bcnt", ifa.branch_cnt_o, 32'(exp_b));
    check("bp_tcnt", ifa.taken_cnt_o, 32'(exp_t));

    // reset asserted while holding a redirect
    drive_a(JAL, 3'b000, 1'b0, 1'b0, 32'h0000_0040);
    ifa.redirect_ready_i = 1'b0;
    @(negedge clk);
    ifa.br_valid_i = 1'b0;
    check("ar_pre_valid", 32'(ifa.redirect_valid_o), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("ar_valid", 32'(ifa.redirect_valid_o), 32'd0);
    check("ar_flush", 32'(ifa.flush_o), 32'd0);
    check("ar_stall", 32'(ifa.stall_o), 32'd0);
    check("ar_pc", ifa.redirect_pc_o, 32'd0);
    check("ar_bcnt", ifa.branch_cnt_o, 32'd0);
    check("ar_tcnt", ifa.taken_cnt_o, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    exp_b = 0;
    exp_t = 0;
    @(negedge clk);
    check("ar_idle_stall", 32'(ifa.stall_o), 32'd0);
    check("ar_idle_valid", 32'(ifa.redirect_valid_o), 32'd0);
    apply_vec(vecs[0], 100);

    // counter saturation with zero-length flush window
    for (int k = 1; k <= 16; k++) begin
      t = 32'h0000_0100 + 32'(k * 8);
      @(negedge clk);
      ifb.br_valid_i  = 1'b1;
      ifb.br_opcode_i = JAL;
      ifb.target_i    = t;
      @(negedge clk);
      ifb.br_valid_i = 1'b0;
      check($sformatf("sat%0d_valid", k), 32'(ifb.redirect_valid_o), 32'd1);
      check($sformatf("sat%0d_pc", k), ifb.redirect_pc_o, t);
      @(negedge clk);
      check($sformatf("sat%0d_idle", k), 32'(ifb.stall_o), 32'd0);
      check($sformatf("sat%0d_noflush", k), 32'(ifb.flush_o), 32'd0);
      sat = (k < 15) ? k : 15;
      check($sformatf("sat%0d_bcnt", k), 32'(ifb.branch_cnt_o), 32'(sat));
      check($sformatf("sat%0d_tcnt", k), 32'(ifb.taken_cnt_o), 32'(sat));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
